div_clk_monitor: RTL and testbench

//  Consumes one divided clock level (e.g. a clk_o1..clk_o4 output of the clock divider) as a plain data signal in the clk domain.

---
 rtl/div_clk_monitor.sv | 174 +++++++++++++++++
 tb/tb_div_clk_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: synchronises a divided clock level, emits rise/fall ticks,
// measures the rise-to-rise period and tracks lock and loss. DIV_CLK_MONITOR_DUTY_EN adds high_cnt_o.
module div_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 64,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_clk_i,
  output logic             rise_tick_o,
  output logic             fall_tick_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic [CNT_W-1:0] edge_cnt_o,
  output logic             locked_o,
  output logic             lost_o
`ifdef DIV_CLK_MONITOR_DUTY_EN
  ,
  output logic [CNT_W-1:0] high_cnt_o
`endif
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
  localparam logic [TW-1:0]    TO_V    = TW'(TIMEOUT);
  localparam logic [MW-1:0]    LAST_M  = MW'(LOCK_COUNT - 1);

  typedef enum logic [2:0] {
    ACQ,
    MEAS,
    LOCKING,
    LOCKED,
    LOST
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       count_inc;
  logic [CNT_W-1:0]       diff;
  logic [TW-1:0]          idle_cnt;
  logic [MW-1:0]          match_cnt, match_d;
  logic                   match;
  logic                   timeout;
  logic                   capture;

  // The last sync stage is compared with its own delayed copy to form the ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= '0;
      sync_q      <= 1'b0;
      rise_tick_o <= 1'b0;
      fall_tick_o <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], div_clk_i};
      sync_q      <= sync[SYNC_STAGES-1];
      rise_tick_o <= sync[SYNC_STAGES-1] & ~sync_q;
      fall_tick_o <= ~sync[SYNC_STAGES-1] & sync_q;
    end
  end

  // A saturated period can never match, so lock is not claimed on a stalled clock.
  always_comb begin
    count_inc = (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + 1'b1;
    diff      = (count_inc >= period_o) ? count_inc - period_o : period_o - count_inc;
    match     = (count_inc != CNT_MAX) && (diff <= TOL_V);
    timeout   = (idle_cnt >= TO_V);
  end

  always_comb begin
    state_d = state;
    match_d = match_cnt;
    capture = 1'b0;
    case (state)
      ACQ: begin
        if (rise_tick_o)  state_d = MEAS;
        else if (timeout) state_d = LOST;
      end
      MEAS: begin
        if (rise_tick_o) begin
          capture = 1'b1;
          state_d = LOCKING;
          match_d = '0;
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOCKING: begin
        if (rise_tick_o) begin
          capture = 1'b1;
          if (!match) begin
            match_d = '0;
          end else if (match_cnt == LAST_M) begin
            state_d = LOCKED;
            match_d = '0;
          end else begin
            match_d = match_cnt + 1'b1;
          end
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (rise_tick_o) begin
          capture = 1'b1;
          if (!match) begin
            state_d = LOCKING;
            match_d = '0;
          end
        end else if (timeout) begin
          state_d = LOST;
        end
      end
      LOST: begin
        if (rise_tick_o) state_d = MEAS;
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACQ;
      match_cnt <= '0;
      locked_o  <= 1'b0;
      lost_o    <= 1'b0;
    end else begin
      state     <= state_d;
      match_cnt <= match_d;
      locked_o  <= (state == LOCKED);
      lost_o    <= (state == LOST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt   <= '0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
      edge_cnt_o   <= '0;
      idle_cnt     <= '0;
    end else begin
      period_vld_o <= capture;
      if (capture) period_o <= count_inc;
      if (rise_tick_o) begin
        period_cnt <= '0;
        edge_cnt_o <= edge_cnt_o + 1'b1;
      end else begin
        period_cnt <= count_inc;
      end
      if (rise_tick_o || fall_tick_o) idle_cnt <= '0;
      else if (!timeout)              idle_cnt <= idle_cnt + 1'b1;
    end
  end

`ifdef DIV_CLK_MONITOR_DUTY_EN
  // Only falls that follow a rise seen outside ACQ/LOST describe a real high phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt_o <= '0;
    end else if (fall_tick_o && state != ACQ && state != LOST) begin
      high_cnt_o <= count_inc;
    end
  end
`endif

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed self-checking bench for div_clk_monitor (CNT_W=8, TIMEOUT=20, LOCK_COUNT=4, TOL=0).
// Define DIV_CLK_MONITOR_DUTY_EN to also check high_cnt_o.
module tb_div_clk_monitor;

  localparam int CNT_W      = 8;
  localparam int TIMEOUT    = 20;
  localparam int LOCK_COUNT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             div_clk;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic [CNT_W-1:0] edge_cnt;
  logic             locked;
  logic             lost;
`ifdef DIV_CLK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] high_cnt;
`endif

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_rise = 0;
  int gap       = 0;
  int ph        = 0;
  int hi_len    = 2;
  int lo_len    = 2;
  int mark      = 0;
  bit wave_en   = 1'b0;

  div_clk_monitor #(
    .SYNC_STAGES(2),
    .CNT_W(CNT_W),
    .TIMEOUT(TIMEOUT),
    .LOCK_COUNT(LOCK_COUNT),
    .TOL(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .div_clk_i(div_clk),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick),
    .period_o(period),
    .period_vld_o(period_vld),
    .edge_cnt_o(edge_cnt),
    .locked_o(locked),
    .lost_o(lost)
`ifdef DIV_CLK_MONITOR_DUTY_EN
    ,
    .high_cnt_o(high_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock step: lands 1 time unit after posedge and advances the div clock waveform.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    cyc++;
    if (wave_en) begin
      ph++;
      if (div_clk && ph >= hi_len) begin
        div_clk = 1'b0;
        ph      = 0;
      end else if (!div_clk && ph >= lo_len) begin
        div_clk = 1'b1;
        ph      = 0;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_rise"},   32'(rise_tick),  0);
    check_output({tag, "_fall"},   32'(fall_tick),  0);
    check_output({tag, "_period"}, 32'(period),     0);
    check_output({tag, "_vld"},    32'(period_vld), 0);
    check_output({tag, "_edge"},   32'(edge_cnt),   0);
    check_output({tag, "_locked"}, 32'(locked),     0);
    check_output({tag, "_lost"},   32'(lost),       0);
  endtask

  // Steps until the requested tick is seen (bounded); records rise-to-rise gap.
  task automatic wait_tick(input bit want_rise, input string tag);
    int n;
    bit seen;
    n = 0;
    do begin
      apply_stimulus();
      n++;
      seen = want_rise ? rise_tick : fall_tick;
    end while (!seen && n < 64);
    check_output(tag, 32'(seen), 1);
    if (want_rise) begin
      gap       = cyc - last_rise;
      last_rise = cyc;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    div_clk = 1'b0;
    $display("[TB] start");
    apply_stimulus();
    apply_stimulus();
    check_reset_state("reset");
    rst_n   = 1'b1;
    ph      = 0;
    wave_en = 1'b1;

    // Toggle every 2 clocks: period 4, fall two cycles after each rise, lock on the 6th rise.
    for (int i = 1; i <= 6; i++) begin
      wait_tick(1'b1, "t1_rise");
      if (i >= 2) check_output("t1_gap", 32'(gap), 4);
      apply_stimulus();
      check_output("t1_vld", 32'(period_vld), (i >= 2) ? 1 : 0);
      check_output("t1_edge", 32'(edge_cnt), 32'(i));
      if (i >= 2) check_output("t1_period", 32'(period), 4);
      check_output("t1_locked_r1", 32'(locked), 0);
      apply_stimulus();
      check_output("t1_fall", 32'(fall_tick), 1);
      check_output("t1_locked_r2", 32'(locked), (i == 6) ? 1 : 0);
    end

    // One stretched high phase gives a single 6-cycle period and drops lock.
    wait_tick(1'b1, "t2_rise_a");
    hi_len = 4;
    wait_tick(1'b1, "t2_rise_b");
    check_output("t2_gap4", 32'(gap), 4);
    hi_len = 2;
    wait_tick(1'b1, "t2_rise_c");
    check_output("t2_gap6", 32'(gap), 6);
    apply_stimulus();
    check_output("t2_period6", 32'(period), 6);
    check_output("t2_vld", 32'(period_vld), 1);
    check_output("t2_locked_hold", 32'(locked), 1);
    apply_stimulus();
    check_output("t2_unlock", 32'(locked), 0);
    // First 4-period mismatches the 6; four matching periods then relock.
    for (int j = 1; j <= 5; j++) begin
      wait_tick(1'b1, "t2_relock_rise");
      apply_stimulus();
      apply_stimulus();
      check_output("t2_relock", 32'(locked), (j == 5) ? 1 : 0);
    end

    // Stop the div clock low: idle reaches TIMEOUT at fall+TIMEOUT+1, then state and decode registers.
    wait_tick(1'b1, "t3_rise");
    wave_en = 1'b0;
    wait_tick(1'b0, "t3_fall");
    mark = cyc;
    repeat (TIMEOUT + 2) apply_stimulus();
    check_output("t3_lost_early", 32'(lost), 0);
    check_output("t3_locked_hold", 32'(locked), 1);
    apply_stimulus();
    check_output("t3_lost", 32'(lost), 1);
    check_output("t3_locked_drop", 32'(locked), 0);
    div_clk = 1'b1;
    ph      = 0;
    wave_en = 1'b1;
    wait_tick(1'b1, "t3_rise_back");
    apply_stimulus();
    check_output("t3_no_vld", 32'(period_vld), 0);
    check_output("t3_lost_hold", 32'(lost), 1);
    apply_stimulus();
    check_output("t3_lost_clear", 32'(lost), 0);

    // Rise tick lands exactly when idle reaches TIMEOUT: rise wins, 23-cycle period accepted.
    wait_tick(1'b1, "t4_rise");
    mark    = cyc;
    wave_en = 1'b0;
    while (cyc < mark + 20) apply_stimulus();
    div_clk = 1'b1;
    ph      = 0;
    wave_en = 1'b1;
    repeat (3) apply_stimulus();
    check_output("t4_rise_late", 32'(rise_tick), 1);
    apply_stimulus();
    check_output("t4_period", 32'(period), 23);
    check_output("t4_vld", 32'(period_vld), 1);
    check_output("t4_lost_r1", 32'(lost), 0);
    apply_stimulus();
    check_output("t4_lost_r2", 32'(lost), 0);

    // Relock, then a one-cycle reset clears everything without a clock edge.
    for (int j = 1; j <= 5; j++) begin
      wait_tick(1'b1, "t5_lock_rise");
      apply_stimulus();
      apply_stimulus();
      check_output("t5_lock", 32'(locked), (j == 5) ? 1 : 0);
    end
    wait_tick(1'b1, "t5_rise");
    rst_n = 1'b0;
    #2;
    check_reset_state("t5_async");
    apply_stimulus();
    rst_n = 1'b1;
    wait_tick(1'b1, "t5_first");
    apply_stimulus();
    check_output("t5_first_vld", 32'(period_vld), 0);
    check_output("t5_first_edge", 32'(edge_cnt), 1);
    check_output("t5_first_locked", 32'(locked), 0);
    wait_tick(1'b1, "t5_second");
    apply_stimulus();
    check_output("t5_second_vld", 32'(period_vld), 1);
    check_output("t5_second_period", 32'(period), 4);
    check_output("t5_second_edge", 32'(edge_cnt), 2);

    // Edge counter wraps from 255 to 0 with CNT_W = 8.
    for (int i = 3; i <= 255; i++) wait_tick(1'b1, "t6_wrap_rise");
    apply_stimulus();
    check_output("t6_edge_max", 32'(edge_cnt), 255);
    wait_tick(1'b1, "t6_wrap_last");
    apply_stimulus();
    check_output("t6_edge_wrap", 32'(edge_cnt), 0);

    // High 3, low 5: period 8 and a 3-cycle high time.
    hi_len = 3;
    lo_len = 5;
    repeat (3) wait_tick(1'b1, "t6_settle");
    wait_tick(1'b1, "t6_rise8");
    check_output("t6_gap8", 32'(gap), 8);
    apply_stimulus();
    check_output("t6_period8", 32'(period), 8);
    check_output("t6_vld8", 32'(period_vld), 1);
`ifdef DIV_CLK_MONITOR_DUTY_EN
    wait_tick(1'b0, "t6_fall");
    apply_stimulus();
    check_output("t6_high_cnt", 32'(high_cnt), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
